// File: rtl/serializer.sv
// rtl/serializer.sv - queue-draining MSB-first bit serializer with per-bit write/ack handshake
// Optional: define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module serializer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clock_10,
  input  logic             reset,
  input  logic [LEN_W-1:0] len_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             deq_out,
  output logic             data_out,
  output logic             write_out,
  input  logic             ack_in,
  output logic             busy_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(WIDTH - 1);
`ifdef SERIALIZER_PARITY_EN
  localparam logic [CNT_W-1:0] PARITY_BIT = CNT_W'(WIDTH);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LAST  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             deq_q, deq_d;
  logic             data_q, data_d;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  // State, datapath and every output are registered together so outputs never glitch.
  always_ff @(posedge clock_10 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      deq_q   <= 1'b0;
      data_q  <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      deq_q   <= deq_d;
      data_q  <= data_d;
      write_q <= write_d;
      busy_q  <= busy_d;
`ifdef SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and next-output logic; deq is a strobe so it defaults low every cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    deq_d   = 1'b0;
    data_d  = data_q;
    write_d = write_q;
    busy_d  = busy_q;
`ifdef SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        write_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = 1'b0;
        cnt_d   = '0;
        if (len_in != '0) begin
          // Pop the head word and capture it on the same edge.
          deq_d   = 1'b1;
          shift_d = data_in;
          busy_d  = 1'b1;
          state_d = LOAD;
`ifdef SERIALIZER_PARITY_EN
          par_d   = ^data_in;
`endif
        end
      end
      LOAD: begin
        busy_d  = 1'b1;
        data_d  = shift_q[WIDTH-1];
        write_d = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Bit advances only on an accepted handshake; otherwise hold data and write.
        if (write_q && ack_in) begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          data_d  = shift_q[WIDTH-2];
`ifdef SERIALIZER_PARITY_EN
          if (cnt_q == LAST_DATA_BIT) begin
            data_d = par_q;
          end else if (cnt_q == PARITY_BIT) begin
            data_d  = 1'b0;
            write_d = 1'b0;
            state_d = LAST;
          end
`else
          if (cnt_q == LAST_DATA_BIT) begin
            data_d  = 1'b0;
            write_d = 1'b0;
            state_d = LAST;
          end
`endif
        end
      end
      LAST: begin
        write_d = 1'b0;
        busy_d  = 1'b0;
        data_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign deq_out   = deq_q;
  assign data_out  = data_q;
  assign write_out = write_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed self-checking bench for serializer
`timescale 1us/1ns
module tb_serializer;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int BITS = WIDTH + 1;
`else
  localparam int BITS = WIDTH;
`endif
  localparam int PERIOD = BITS + 3;

  logic             clock_10 = 1'b0;
  logic             reset    = 1'b0;
  logic [LEN_W-1:0] len_in   = '0;
  logic [WIDTH-1:0] data_in  = '0;
  logic             deq_out;
  logic             data_out;
  logic             write_out;
  logic             ack_in   = 1'b1;
  logic             busy_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock_10  (clock_10),
    .reset     (reset),
    .len_in    (len_in),
    .data_in   (data_in),
    .deq_out   (deq_out),
    .data_out  (data_out),
    .write_out (write_out),
    .ack_in    (ack_in),
    .busy_out  (busy_out)
  );

  always #50 clock_10 = ~clock_10;

  always @(posedge clock_10) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_deq"},   deq_out,   1'b0);
    check({tag, "_data"},  data_out,  1'b0);
    check({tag, "_write"}, write_out, 1'b0);
    check({tag, "_busy"},  busy_out,  1'b0);
  endtask

  // Waits up to budget falling edges for the dequeue strobe.
  task automatic wait_deq(input string tag, input int budget);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clock_10);
      if (deq_out) seen = 1'b1;
      n++;
    end
    check({tag, "_deq_seen"}, seen, 1'b1);
  endtask

  // With ack held high, expects the word's bits on consecutive cycles, then write low.
  task automatic expect_word(input string tag, input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      @(negedge clock_10);
      check({tag, "_write"}, write_out, 1'b1);
      check({tag, "_bit"},   data_out,  w[i]);
      check({tag, "_nodeq"}, deq_out,   1'b0);
    end
`ifdef SERIALIZER_PARITY_EN
    @(negedge clock_10);
    check({tag, "_par_write"}, write_out, 1'b1);
    check({tag, "_par_bit"},   data_out,  ^w);
`endif
    @(negedge clock_10);
    check({tag, "_end_write"}, write_out, 1'b0);
    check({tag, "_end_busy"},  busy_out,  1'b1);
    @(negedge clock_10);
    check({tag, "_idle_busy"}, busy_out,  1'b0);
  endtask

  logic [WIDTH-1:0] q [9];

  initial begin
    int head;
    int prev;
    int ndeq;
    int nbits;
    int word_idx;
    int ndeq_empty;
    int nbusy_empty;
    logic [WIDTH-1:0] acc;

    // Reset held with a non-empty queue: nothing may move.
    reset   = 1'b0;
    len_in  = 8'd3;
    data_in = 8'hA5;
    #10;
    check_outputs_zero("rst_t10");
    @(negedge clock_10);
    check_outputs_zero("rst_n1");
    @(negedge clock_10);
    check_outputs_zero("rst_n2");
    reset = 1'b1;

    // First dequeue one edge after release, then A5 serialized MSB first.
    wait_deq("a5", 1);
    len_in = 8'd1;
    data_in = 8'hA5;
    @(posedge clock_10);
    #1;
    len_in = 8'd0;
    @(negedge clock_10);
    check("a5_first_write", write_out, 1'b1);
    check("a5_first_bit", data_out, 1'b1);
    check("a5_first_busy", busy_out, 1'b1);
    for (int i = WIDTH - 2; i >= 0; i--) begin
      @(negedge clock_10);
      check("a5_write", write_out, 1'b1);
      check("a5_bit", data_out, ((8'hA5 >> i) & 8'h01) != 0);
    end
`ifdef SERIALIZER_PARITY_EN
    @(negedge clock_10);
    check("a5_par", data_out, 1'b0);
`endif
    @(negedge clock_10);
    check("a5_end_write", write_out, 1'b0);
    @(negedge clock_10);
    check("a5_idle_busy", busy_out, 1'b0);

    // Back-to-back: nine queued bytes, spacing and order checked.
    for (int i = 0; i < 9; i++) q[i] = 8'((i + 1) * 8'h11);
    head = 0;
    prev = -1;
    ndeq = 0;
    nbits = 0;
    word_idx = 0;
    acc = '0;
    len_in = 8'd9;
    data_in = q[0];
    for (int n = 0; n < 9 * PERIOD + 20 && word_idx < 9; n++) begin
      @(negedge clock_10);
      if (write_out) begin
        if (nbits < WIDTH) acc = {acc[WIDTH-2:0], data_out};
        else check("b2b_parity", data_out, ^q[word_idx]);
        nbits++;
        if (nbits == BITS) begin
          check("b2b_word", acc, q[word_idx]);
          word_idx++;
          nbits = 0;
        end
      end
      if (deq_out) begin
        ndeq++;
        if (prev >= 0) check("b2b_spacing", cyc - prev, PERIOD);
        prev = cyc;
        head++;
        len_in = LEN_W'(9 - head);
        data_in = (head < 9) ? q[head] : 8'h00;
      end
    end
    check("b2b_deq_count", ndeq, 9);
    check("b2b_word_count", word_idx, 9);
    @(negedge clock_10);
    @(negedge clock_10);
    check("b2b_idle_busy", busy_out, 1'b0);

    // Stalled handshake: first bit of 80 held for five cycles.
    data_in = 8'h80;
    len_in = 8'd1;
    ack_in = 1'b0;
    wait_deq("stall", 4);
    len_in = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_10);
      check("stall_write", write_out, 1'b1);
      check("stall_bit", data_out, 1'b1);
    end
    ack_in = 1'b1;
    for (int i = 0; i < WIDTH - 1; i++) begin
      @(negedge clock_10);
      check("stall_rest_write", write_out, 1'b1);
      check("stall_rest_bit", data_out, 1'b0);
    end
`ifdef SERIALIZER_PARITY_EN
    @(negedge clock_10);
    check("stall_par", data_out, 1'b1);
`endif
    @(negedge clock_10);
    check("stall_end_write", write_out, 1'b0);
    @(negedge clock_10);

    // Empty queue: no dequeue, never busy.
    ndeq_empty = 0;
    nbusy_empty = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock_10);
      if (deq_out) ndeq_empty++;
      if (busy_out) nbusy_empty++;
    end
    check("empty_deq", ndeq_empty, 0);
    check("empty_busy", nbusy_empty, 0);

    // Reset mid-word after three accepted bits of FF.
    data_in = 8'hFF;
    len_in = 8'd1;
    wait_deq("midrst", 4);
    len_in = 8'd0;
    for (int i = 0; i < 4; i++) @(negedge clock_10);
    check("midrst_pre_write", write_out, 1'b1);
    #10;
    reset = 1'b0;
    #1;
    check_outputs_zero("midrst_async");
    @(negedge clock_10);
    reset = 1'b1;
    ndeq_empty = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_10);
      if (deq_out || write_out) ndeq_empty++;
    end
    check("midrst_no_resume", ndeq_empty, 0);
    data_in = 8'h3C;
    len_in = 8'd1;
    wait_deq("fresh", 2);
    len_in = 8'd0;
    expect_word("fresh", 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
